// File: rtl/irs_readout_fifo_bank.sv
// Per-daughter 16-bit sample FIFOs filled by the IRS readout path and drained by the DMA
// controller through a single addressed pop port with one-cycle read latency.
module irs_readout_fifo_bank #(
  parameter int MAX_DAUGHTERS = 4,
  parameter int NUM_DAUGHTERS = 4,
  parameter int DEPTH         = 1024,
  parameter int NMXD_BITS     = (MAX_DAUGHTERS > 1) ? $clog2(MAX_DAUGHTERS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clear_i,
  input  logic [16*MAX_DAUGHTERS-1:0] wr_dat_i,
  input  logic [MAX_DAUGHTERS-1:0]    wr_i,
  output logic [MAX_DAUGHTERS-1:0]    full_o,
  output logic [MAX_DAUGHTERS-1:0]    overflow_o,
  input  logic [NMXD_BITS-1:0]        irs_addr_i,
  input  logic                        irs_read_i,
  output logic [15:0]                 irs_dat_o,
  output logic                        irs_valid_o,
  output logic                        irs_empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [MAX_DAUGHTERS-1:0]    empty_s;
  logic [MAX_DAUGHTERS-1:0]    full_s;
  logic [MAX_DAUGHTERS-1:0]    overflow_s;
  logic [16*MAX_DAUGHTERS-1:0] bank_q_s;
  logic                        sel_empty_s;
  logic                        pop_s;
  logic                        valid_r;
  logic [NMXD_BITS-1:0]        sel_r;

  // Empty flag of the addressed daughter; addresses beyond the port vectors read as empty
  always_comb begin
    if (int'(irs_addr_i) < MAX_DAUGHTERS) begin
      sel_empty_s = empty_s[irs_addr_i];
    end else begin
      sel_empty_s = 1'b1;
    end
  end

  assign pop_s = irs_read_i & ~sel_empty_s & ~clear_i;

  for (genvar d = 0; d < MAX_DAUGHTERS; d++) begin : g_slot
    if (d < NUM_DAUGHTERS) begin : g_pop
      logic [15:0]   mem [DEPTH];
      logic [AW-1:0] wp_r;
      logic [AW-1:0] rp_r;
      logic [AW:0]   cnt_r;
      logic          ovf_r;
      logic [15:0]   q_r;
      logic          wr_ok_s;
      logic          rd_ok_s;

      assign full_s[d]     = (cnt_r == DEPTH_CNT);
      assign empty_s[d]    = (cnt_r == '0);
      assign overflow_s[d] = ovf_r;
      assign wr_ok_s       = wr_i[d] & ~full_s[d] & ~clear_i;
      assign rd_ok_s       = pop_s & (irs_addr_i == NMXD_BITS'(d));
      assign bank_q_s[16*d +: 16] = q_r;

      // Sample storage write port
      always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
          mem[wp_r] <= wr_dat_i[16*d +: 16];
        end
      end

      // Registered read port; only moves on an accepted pop so the word is held afterwards
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          q_r <= 16'h0000;
        end else if (rd_ok_s) begin
          q_r <= mem[rp_r];
        end
      end

      // Pointers, occupancy and sticky overflow; a pop does not make room for a same-cycle write
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          wp_r  <= '0;
          rp_r  <= '0;
          cnt_r <= '0;
          ovf_r <= 1'b0;
        end else if (clear_i) begin
          wp_r  <= '0;
          rp_r  <= '0;
          cnt_r <= '0;
          ovf_r <= 1'b0;
        end else begin
          if (wr_ok_s) wp_r <= wp_r + AW'(1);
          if (rd_ok_s) rp_r <= rp_r + AW'(1);
          case ({wr_ok_s, rd_ok_s})
            2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
            default: cnt_r <= cnt_r;
          endcase
          if (wr_i[d] && full_s[d]) ovf_r <= 1'b1;
        end
      end
    end else begin : g_none
      logic unused_s;
      assign unused_s      = ^{wr_i[d], wr_dat_i[16*d +: 16]};
      assign full_s[d]     = 1'b1;
      assign empty_s[d]    = 1'b1;
      assign overflow_s[d] = 1'b0;
      assign bank_q_s[16*d +: 16] = 16'h0000;
    end
  end

  // Valid strobe and the daughter whose read register feeds irs_dat_o
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
      sel_r   <= '0;
    end else if (clear_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= pop_s;
      if (pop_s) sel_r <= irs_addr_i;
    end
  end

  assign irs_dat_o   = bank_q_s[int'(sel_r)*16 +: 16];
  assign irs_valid_o = valid_r;
  assign irs_empty_o = sel_empty_s;
  assign full_o      = full_s;
  assign overflow_o  = overflow_s;

endmodule

// File: tb/tb_irs_readout_fifo_bank.sv
// Bench for irs_readout_fifo_bank: table vectors, directed corner sequences and random traffic
// compared every cycle against a queue-based reference model.
module tb_irs_readout_fifo_bank;

  localparam int ND    = 4;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [63:0]   wr_dat_i = '0;
  logic [3:0]    wr_i = '0;
  logic [3:0]    full_o;
  logic [3:0]    overflow_o;
  logic [1:0]    irs_addr_i = '0;
  logic          irs_read_i = 1'b0;
  logic [15:0]   irs_dat_o;
  logic          irs_valid_o;
  logic          irs_empty_o;

  irs_readout_fifo_bank #(
    .MAX_DAUGHTERS(ND), .NUM_DAUGHTERS(ND), .DEPTH(DEPTH), .NMXD_BITS(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .clear_i(clear_i), .wr_dat_i(wr_dat_i), .wr_i(wr_i),
    .full_o(full_o), .overflow_o(overflow_o), .irs_addr_i(irs_addr_i), .irs_read_i(irs_read_i),
    .irs_dat_o(irs_dat_o), .irs_valid_o(irs_valid_o), .irs_empty_o(irs_empty_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model: one queue per daughter plus the visible read-side state
  logic [15:0] mq [ND][$];
  logic [3:0]  movf;
  logic        mvalid;
  logic [15:0] mdat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) mq[d].delete();
    movf = 4'b0000; mvalid = 1'b0; mdat = 16'h0000;
  endtask

  function automatic logic [3:0] mfull();
    logic [3:0] f;
    for (int d = 0; d < ND; d++) f[d] = (mq[d].size() == DEPTH);
    return f;
  endfunction

  task automatic model_edge(input logic [3:0] wr, input logic [63:0] dat, input logic clr,
                            input logic [1:0] addr, input logic rd);
    logic [3:0] fpre;
    if (clr) begin
      for (int d = 0; d < ND; d++) mq[d].delete();
      movf = 4'b0000; mvalid = 1'b0;
    end else begin
      fpre = mfull();
      if (rd && mq[addr].size() > 0) begin
        mdat = mq[addr].pop_front();
        mvalid = 1'b1;
      end else begin
        mvalid = 1'b0;
      end
      for (int d = 0; d < ND; d++) begin
        if (wr[d]) begin
          if (fpre[d]) movf[d] = 1'b1;
          else mq[d].push_back(dat[16*d +: 16]);
        end
      end
    end
  endtask

  // One clock: drive, check combinational flags before the edge, check registered outputs after
  task automatic step(input logic [3:0] wr, input logic [63:0] dat, input logic clr,
                      input logic [1:0] addr, input logic rd,
                      output logic pre_empty, output logic post_valid, output logic [15:0] post_dat);
    wr_i = wr; wr_dat_i = dat; clear_i = clr; irs_addr_i = addr; irs_read_i = rd;
    #1;
    pre_empty = irs_empty_o;
    chk("empty", 32'(irs_empty_o), 32'(mq[addr].size() == 0));
    chk("full", 32'(full_o), 32'(mfull()));
    @(posedge clk);
    model_edge(wr, dat, clr, addr, rd);
    #1;
    post_valid = irs_valid_o;
    post_dat = irs_dat_o;
    chk("valid", 32'(irs_valid_o), 32'(mvalid));
    chk("data", 32'(irs_dat_o), 32'(mdat));
    chk("overflow", 32'(overflow_o), 32'(movf));
  endtask

  typedef struct {
    logic [3:0]  wr;
    logic [15:0] wdat;
    logic        clr;
    logic [1:0]  addr;
    logic        rd;
    logic        e_empty;
    logic        e_valid;
    logic [15:0] e_dat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic e, v;
    logic [15:0] q;
    logic [63:0] dat;
    logic [15:0] expw [$];
    int cnt;

    tbl[0]  = '{4'b0001, 16'h1111, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{4'b0001, 16'h2222, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{4'b0001, 16'h3333, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{4'b0000, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'h1111};
    tbl[4]  = '{4'b0000, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'h2222};
    tbl[5]  = '{4'b0000, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 16'h3333};
    tbl[6]  = '{4'b0000, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h3333};
    tbl[7]  = '{4'b0100, 16'hABCD, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 16'h3333};
    tbl[8]  = '{4'b0000, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 16'hABCD};
    tbl[9]  = '{4'b0000, 16'h0000, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 16'hABCD};
    tbl[10] = '{4'b1000, 16'h5555, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 16'hABCD};
    tbl[11] = '{4'b0000, 16'h0000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'hABCD};
    tbl[12] = '{4'b0000, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 16'hABCD};

    model_reset();
    #1;
    chk("rst_valid", 32'(irs_valid_o), 32'd0);
    chk("rst_empty", 32'(irs_empty_o), 32'd1);
    chk("rst_data", 32'(irs_dat_o), 32'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    chk("rst_full", 32'(full_o), 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);

    // table vectors: basic FIFO, write+read on empty daughter, clear with pop
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wr, {4{tbl[i].wdat}}, tbl[i].clr, tbl[i].addr, tbl[i].rd, e, v, q);
      chk($sformatf("tbl%0d_empty", i), 32'(e), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_valid", i), 32'(v), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), 32'(q), 32'(tbl[i].e_dat));
    end

    // fill daughter 1, then one extra write that must be dropped
    for (int i = 0; i < DEPTH; i++) step(4'b0010, {4{16'(i)}}, 1'b0, 2'd1, 1'b0, e, v, q);
    chk("full_d1", 32'(full_o[1]), 32'd1);
    step(4'b0010, {4{16'hDEAD}}, 1'b0, 2'd1, 1'b0, e, v, q);
    chk("ovf_d1", 32'(overflow_o[1]), 32'd1);
    cnt = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      step(4'b0000, 64'h0, 1'b0, 2'd1, 1'b1, e, v, q);
      if (v) begin
        chk("drain_word", 32'(q), 32'(cnt));
        cnt++;
      end
    end
    chk("drain_count", 32'(cnt), 32'(DEPTH));
    chk("ovf_sticky", 32'(overflow_o[1]), 32'd1);

    // asynchronous reset while a popped word is being presented
    step(4'b0001, {4{16'h7777}}, 1'b0, 2'd0, 1'b0, e, v, q);
    step(4'b0000, 64'h0, 1'b0, 2'd0, 1'b1, e, v, q);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_valid", 32'(irs_valid_o), 32'd0);
    chk("midrst_empty", 32'(irs_empty_o), 32'd1);
    chk("midrst_ovf", 32'(overflow_o), 32'h0);
    chk("midrst_data", 32'(irs_dat_o), 32'h0000);
    model_reset();
    @(posedge clk);
    #1 rst_n_i = 1'b1;
    chk("postrst_full", 32'(full_o), 32'h0);

    // DMA-style sweep: 65 words per daughter, one idle cycle on each address change
    for (int i = 0; i < 65; i++) begin
      for (int d = 0; d < ND; d++) dat[16*d +: 16] = {4'(d), 12'(i)};
      step(4'b1111, dat, 1'b0, 2'd0, 1'b0, e, v, q);
    end
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 65; i++) expw.push_back({4'(d), 12'(i)});
    cnt = 0;
    for (int d = 0; d < ND; d++) begin
      step(4'b0000, 64'h0, 1'b0, 2'(d), 1'b0, e, v, q);
      for (int i = 0; i < 65; i++) begin
        step(4'b0000, 64'h0, 1'b0, 2'(d), 1'b1, e, v, q);
        if (v) begin
          cnt++;
          if (expw.size() > 0) chk("sweep_word", 32'(q), 32'(expw.pop_front()));
          else chk("sweep_extra", 32'(q), 32'hFFFFFFFF);
        end
      end
    end
    chk("sweep_count", 32'(cnt), 32'd260);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      dat = {$urandom, $urandom};
      step(4'($urandom), dat, ($urandom_range(0, 199) == 0), 2'($urandom),
           ($urandom_range(0, 9) < 7), e, v, q);
    end

    // final clear: every daughter reads empty and no overflow remains
    step(4'b0000, 64'h0, 1'b1, 2'd0, 1'b1, e, v, q);
    chk("clr_valid", 32'(v), 32'd0);
    for (int d = 0; d < ND; d++) begin
      step(4'b0000, 64'h0, 1'b0, 2'(d), 1'b0, e, v, q);
      chk("clr_empty", 32'(e), 32'd1);
    end
    chk("clr_ovf", 32'(overflow_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
